// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage
// Registered decode stage between fetch and execute. Each accepted instruction
// word is split into opcode/dest/src/imm fields and put into a class. A load-use
// hazard flag is computed against the previously accepted instruction. An
// output register plus a skid register give one-cycle latency at full
// throughput while keeping in_ready a registered signal.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// - Upstream side: in_valid/in_ready.
// - Downstream side: out_valid/out_ready.
// - While out_valid && !out_ready, the output entry is held stable.
module instruction_decode_stage #(
    parameter  int INSTR_W = 16,
    parameter  int OPC_W   = 4,
    parameter  int REG_W   = 4,
    parameter  int CNT_W   = 16,
    localparam int IMM_W   = INSTR_W - OPC_W - 2*REG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_W-1:0]   out_dest,
    output logic [REG_W-1:0]   out_src,
    output logic [IMM_W-1:0]   out_imm,
    output logic               out_is_nop,
    output logic               out_is_load,
    output logic               out_is_store,
    output logic               out_is_alu,
    output logic               out_is_jump,
    output logic               out_load_use,
    output logic [CNT_W-1:0]   decode_count
);

    // Buffered entry layout: {instruction word, class[4:0], load_use}.
    // The class field is ordered {nop, load, store, alu, jump}.
    // The raw word is kept because the fields are simply its bit slices.
    localparam int ENT_W = INSTR_W + 6;

    logic [OPC_W-1:0] w_opc;
    logic [3:0]       w_top;
    logic [REG_W-1:0] w_dest;
    logic [REG_W-1:0] w_src;
    logic [4:0]       w_cls;
    logic             w_load_use;
    logic [ENT_W-1:0] w_entry;
    logic             w_accept;
    logic             w_xfer;

    logic             r_out_valid;
    logic [ENT_W-1:0] r_out;
    logic             r_skid_valid;
    logic [ENT_W-1:0] r_skid;
    logic             r_ld_valid;
    logic [REG_W-1:0] r_ld_dest;
    logic [CNT_W-1:0] r_count;

    assign w_opc  = in_instr[INSTR_W-1 -: OPC_W];
    assign w_top  = w_opc[OPC_W-1 -: 4];
    assign w_dest = in_instr[INSTR_W-OPC_W-1 -: REG_W];
    assign w_src  = in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];

    // Priority classification on the top four opcode bits; lower opcode bits are ignored.
    always_comb begin
        w_cls = 5'b00000;
        if (w_top[3])      w_cls = 5'b00001;  // jump
        else if (w_top[2]) w_cls = 5'b00010;  // alu
        else if (w_top[1]) w_cls = 5'b00100;  // store
        else if (w_top[0]) w_cls = 5'b01000;  // load
        else               w_cls = 5'b10000;  // nop
    end

    assign w_load_use = r_ld_valid && !w_cls[4] && (w_src == r_ld_dest);
    assign w_entry    = {in_instr, w_cls, w_load_use};

    // The skid register is full exactly when the upstream must stall.
    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    // Two-entry FIFO: output register first, skid register behind it; flush wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || w_xfer) begin
            // The output slot is free this cycle: the oldest entry moves into it.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_entry;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_entry;
            r_skid_valid <= 1'b1;
        end
    end

    // Remember whether the last accepted instruction was a load, and its destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_valid <= 1'b0;
            r_ld_dest  <= '0;
        end else if (flush) begin
            r_ld_valid <= 1'b0;
        end else if (w_accept) begin
            r_ld_valid <= w_cls[3];
            r_ld_dest  <= w_dest;
        end
    end

    // Saturating count of output transfers. A transfer in a flush cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_xfer && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_opcode   = r_out[ENT_W-1 -: OPC_W];
    assign out_dest     = r_out[ENT_W-OPC_W-1 -: REG_W];
    assign out_src      = r_out[ENT_W-OPC_W-REG_W-1 -: REG_W];
    assign out_imm      = r_out[6 +: IMM_W];
    assign out_is_nop   = r_out[5];
    assign out_is_load  = r_out[4];
    assign out_is_store = r_out[3];
    assign out_is_alu   = r_out[2];
    assign out_is_jump  = r_out[1];
    assign out_load_use = r_out[0];
    assign decode_count = r_count;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Testbench for instruction_decode_stage.
// - A second instance with a 4-bit counter shares all inputs; only its counter is observed.
// - The reference model treats the stage as a two-deep FIFO of decoded words.
module tb_instruction_decode_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode, out_dest, out_src, out_imm;
    logic        out_is_nop, out_is_load, out_is_store, out_is_alu, out_is_jump;
    logic        out_load_use;
    logic [15:0] decode_count;

    logic        c4_in_ready, c4_out_valid;
    logic [3:0]  c4_opcode, c4_dest, c4_src, c4_imm;
    logic        c4_nop, c4_load, c4_store, c4_alu, c4_jump, c4_lu;
    logic [3:0]  c4_count;

    instruction_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_dest(out_dest), .out_src(out_src), .out_imm(out_imm),
        .out_is_nop(out_is_nop), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_alu(out_is_alu), .out_is_jump(out_is_jump), .out_load_use(out_load_use),
        .decode_count(decode_count)
    );

    instruction_decode_stage #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(c4_out_valid), .out_ready(out_ready),
        .out_opcode(c4_opcode), .out_dest(c4_dest), .out_src(c4_src), .out_imm(c4_imm),
        .out_is_nop(c4_nop), .out_is_load(c4_load), .out_is_store(c4_store),
        .out_is_alu(c4_alu), .out_is_jump(c4_jump), .out_load_use(c4_lu),
        .decode_count(c4_count)
    );

    // Observed entry: {opcode, dest, src, imm, nop, load, store, alu, jump, load_use}.
    logic [21:0] obs;
    assign obs = {out_opcode, out_dest, out_src, out_imm, out_is_nop, out_is_load,
                  out_is_store, out_is_alu, out_is_jump, out_load_use};

    // ---------------- scoreboard / model ----------------
    logic [21:0] exp_q[$];
    bit          m_ldv;
    logic [3:0]  m_ldd;
    int          m_cnt, m_cnt4;
    bit          m_acc;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] send_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [21:0] model_decode(input logic [15:0] ins, input bit ldv,
                                                 input logic [3:0] ldd);
        int         opc;
        logic [4:0] cls;
        bit         lu;
        opc = int'(ins[15:12]);
        if (opc >= 8)      cls = 5'b00001;
        else if (opc >= 4) cls = 5'b00010;
        else if (opc >= 2) cls = 5'b00100;
        else if (opc == 1) cls = 5'b01000;
        else               cls = 5'b10000;
        lu = ldv && (opc != 0) && (ins[7:4] == ldd);
        return {ins, cls, lu};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ldv  = 0;
        m_ldd  = '0;
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) chk("out_data", obs, exp_q[0]);
        chk("decode_count", decode_count, m_cnt);
        chk("decode_count_c4", c4_count, m_cnt4);
    endtask

    // Called at posedge+1 with the inputs for this cycle already driven.
    task automatic cycle();
        bit xfer;
        check_outputs();
        xfer  = (exp_q.size() > 0) && out_ready;
        m_acc = in_valid && (exp_q.size() < 2);
        if (xfer) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (flush) begin
            exp_q.delete();
            m_ldv = 0;
        end else begin
            if (xfer) void'(exp_q.pop_front());
            if (m_acc) begin
                exp_q.push_back(model_decode(in_instr, m_ldv, m_ldd));
                m_ldv = (in_instr[15:12] == 4'd1);
                m_ldd = in_instr[11:8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Push send_q through the stage, stalling the output for the first 'stall' cycles.
    task automatic run_seq(input int stall);
        int idx;
        bit done;
        idx  = 0;
        done = 0;
        for (int c = 0; c < 200; c++) begin
            if (idx >= send_q.size() && exp_q.size() == 0) begin
                done = 1;
                break;
            end
            in_valid  = (idx < send_q.size());
            in_instr  = in_valid ? send_q[idx] : 16'h0;
            out_ready = (c >= stall);
            flush     = 1'b0;
            cycle();
            if (in_valid && m_acc) idx++;
        end
        chk("seq_done", done, 1);
        in_valid = 1'b0;
        send_q.delete();
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        // Reset state: everything zero, in_ready high.
        chk("rst_fields", obs, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", decode_count, 0);

        // Field decode of 16'h1234.
        in_valid = 1'b1; in_instr = 16'h1234; out_ready = 1'b1; flush = 1'b0;
        cycle();
        in_valid = 1'b0;
        chk("f_opcode", out_opcode, 1);
        chk("f_dest", out_dest, 2);
        chk("f_src", out_src, 3);
        chk("f_imm", out_imm, 4);
        chk("f_is_load", out_is_load, 1);
        idle(2);

        // Classification patterns.
        send_q = '{16'h2A51, 16'h3000, 16'h5000, 16'h9000, 16'hF000, 16'h0000};
        run_seq(0);

        // Load-use: direct dependency flagged.
        in_valid = 1'b1; in_instr = 16'h1234; cycle();
        in_instr = 16'h5320; cycle();
        in_valid = 1'b0;
        chk("lu_direct", out_load_use, 1);
        idle(2);
        // Intervening alu and nop consumers do not flag.
        send_q = '{16'h1234, 16'h5000, 16'h5320, 16'h1234, 16'h0020};
        run_seq(0);

        // Backpressure: A,B,C,D with output stalled for 3 cycles.
        send_q = '{16'h1A11, 16'h2B22, 16'h5C33, 16'h9D44};
        run_seq(3);

        // Flush with both entries full and an input offered in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h1234; cycle();
        in_instr = 16'h1234; cycle();
        flush = 1'b1; in_instr = 16'h5320; cycle();
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1; in_instr = 16'h5320; cycle();
        in_valid = 1'b0;
        chk("flush_ld_cleared", out_load_use, 0);
        idle(2);

        // Asynchronous reset pulse mid-stream, away from a clock edge.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 16'h5111; cycle();
        in_instr = 16'h5222; cycle();
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", decode_count, 0);
        chk("arst_in_ready", in_ready, 1);
        model_reset();
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Counter: 20 transfers saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) send_q.push_back(16'h4000 + 16'(i));
        run_seq(0);
        chk("cnt4_sat", c4_count, 15);
        chk("cnt16_20", decode_count, 20);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !m_acc) || $urandom_range(0, 3) == 0) begin
                in_instr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                            4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
